// File: rtl/mem_access_unit_pkg.sv
// Shared types and lane helpers for the data-memory access unit.
// Sizes, FSM states and byte-lane masks used by the FSM and the lane datapath.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WRITE  = 3'd4,
    RESP   = 3'd5
  } state_e;

  typedef enum logic {
    LANE_EXTRACT = 1'b0,
    LANE_MERGE   = 1'b1
  } lane_fn_e;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_W = 32'hFFFF_FFFF;

  // Mask of the bytes touched by an access of size sz at byte offset off.
  function automatic logic [31:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [31:0] base;
    case (sz)
      SZ_B:    base = LANE_MASK_B;
      SZ_H:    base = LANE_MASK_H;
      default: base = LANE_MASK_W;
    endcase
    return base << {off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational byte-lane datapath: extracts/extends a loaded lane, or merges
// store data into a word. FN selects which result drives o_word.
module mau_lane
  import mau_pkg::*;
#(
  parameter lane_fn_e FN = LANE_EXTRACT
) (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_word
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_extract;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  always_comb begin
    w_shamt   = {i_offset, 3'b000};
    w_shifted = i_word >> w_shamt;
    w_extract = i_word;
    case (size_e'(i_size))
      SZ_B:    w_extract = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
      SZ_H:    w_extract = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_extract = i_word;
    endcase

    // Replace only the addressed lane(s); the rest of the word is preserved.
    w_mask   = lane_mask(size_e'(i_size), i_offset);
    w_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

    o_word = (FN == LANE_EXTRACT) ? w_extract : w_merged;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: turns pipeline load/store
// requests into word-wide memory cycles, with read-modify-write for sub-word stores.
//
// Handshake: a request transfers on a posedge where i_req_valid && o_req_ready;
// o_req_ready is high only in IDLE and request inputs are ignored otherwise.
// o_resp_valid is a single-cycle pulse with no back-pressure.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy,
  output logic [31:0] o_mem_a,
  output logic [31:0] o_mem_wd,
  output logic        o_mem_re,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rd,
  output logic [2:0]  o_dbg_state
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_addr;
  size_e       r_size;
  logic        r_signed;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [31:0] w_extract;
  logic [31:0] w_merged;
  logic [31:0] w_word_idx;

  // Request classification; only feeds next-state and the latched error flag.
  always_comb begin
    w_misaligned = 1'b0;
    case (size_e'(i_req_size))
      SZ_B:    w_misaligned = 1'b0;
      SZ_H:    w_misaligned = i_req_addr[0];
      SZ_W:    w_misaligned = (i_req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
    w_out_of_range = ({2'b00, i_req_addr[31:2]} >= 32'(MEM_WORDS));
    w_err          = w_misaligned | w_out_of_range;
  end

  assign w_word_idx  = {2'b00, r_addr[31:2]};
  assign o_dbg_state = r_state;

  mau_lane #(.FN(LANE_EXTRACT)) u_extract (
    .i_word   (i_mem_rd),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_word   (w_extract)
  );

  mau_lane #(.FN(LANE_MERGE)) u_merge (
    .i_word   (r_merge),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_word   (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_size   <= SZ_B;
      r_signed <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr   <= i_req_addr;
            r_size   <= size_e'(i_req_size);
            r_signed <= i_req_signed;
            r_we     <= i_req_we;
            r_wdata  <= i_req_wdata;
            r_err    <= w_err;
            r_rdata  <= '0;
          end
        end
        READ:    r_rdata <= w_extract;
        RMW_RD:  r_merge <= i_mem_rd;
        default: ;
      endcase
    end
  end

  // Outputs decode from state and latched registers only.
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_busy       = 1'b1;
    o_mem_re     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_a      = '0;
    o_mem_wd     = '0;
    o_resp_valid = 1'b0;
    o_resp_rdata = '0;
    o_resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) begin
          if (w_err)                             w_next = RESP;
          else if (!i_req_we)                    w_next = READ;
          else if (size_e'(i_req_size) == SZ_W)  w_next = WRITE;
          else                                   w_next = RMW_RD;
        end
      end
      READ: begin
        o_mem_re = 1'b1;
        o_mem_a  = w_word_idx;
        w_next   = RESP;
      end
      RMW_RD: begin
        o_mem_re = 1'b1;
        o_mem_a  = w_word_idx;
        w_next   = RMW_WR;
      end
      RMW_WR: begin
        o_mem_we = 1'b1;
        o_mem_a  = w_word_idx;
        o_mem_wd = w_merged;
        w_next   = RESP;
      end
      WRITE: begin
        o_mem_we = 1'b1;
        o_mem_a  = w_word_idx;
        o_mem_wd = r_wdata;
        w_next   = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = r_we ? 32'h0 : r_rdata;
        o_resp_err   = r_err;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: converts pipeline load/store requests into word-wide mem_a/mem_wd/mem_re/mem_we cycles.
- Handles byte, halfword and word accesses, with sign or zero extension on loads.
- Performs read-modify-write for sub-word stores, because the data memory writes whole words only.
- Sits between the MEM-stage pipeline register and data_memory; flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 256, depth of attached data memory in 32-bit words; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  pipeline request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready at posedge
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as error)
- req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores/errors)
- resp_err  out  1  misaligned, out-of-range or reserved size
- busy  out  1  state != IDLE (hazard-unit stall)
- mem_a  out  32  word index = {2'b00, addr[31:2]}
- mem_wd  out  32  write data
- mem_re  out  1  read enable; mem_rd sampled same cycle (combinational read)
- mem_we  out  1  write enable; memory commits at next posedge
- mem_rd  in  32  read data

Behaviour:
- Byte lanes are little-endian: offset addr[1:0]=0 maps to bits [7:0]; halfword offset 2 maps to bits [31:16].
- On accept, latch addr, size, signed, we and wdata. Inputs are ignored until the unit returns to IDLE.
- mem_re, mem_we, mem_a, mem_wd and resp_* are decoded from the state and latched registers only, with no combinational path from req_* inputs.
- mem_re and mem_we are never high in the same cycle.
- States:
  - IDLE: req_ready=1. On accept:
    - error (size==3, half with addr[0]!=0, word with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS) -> RESP with err latched
    - load -> READ
    - word store -> WRITE
    - byte/half store -> RMW_RD
  - READ: mem_re=1. Extract lane and extend, latch into rdata -> RESP.
  - RMW_RD: mem_re=1. Latch mem_rd into merge register -> RMW_WR.
  - RMW_WR: mem_we=1, mem_wd = merge register with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0] -> RESP.
  - WRITE: mem_we=1, mem_wd=wdata -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency, counted from the accept edge = cycle 0, to the resp_valid cycle:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Throughput: one request per 3 or 4 cycles. A new request is accepted in IDLE the cycle after RESP.
- Error path: no mem_re/mem_we asserted; resp_rdata=0.
- Reset (async, any state): state=IDLE; all outputs 0 except req_ready=1; latched registers cleared. A store interrupted before RMW_WR/WRITE produces no memory write, and no response is issued for it.

Decomposition:
- Package mau_pkg holds:
  - size_e {SZ_B, SZ_H, SZ_W, SZ_RSV}
  - state_e {IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP}
  - localparams for byte-lane masks
- Sub-module mau_lane (combinational) provides:
  - extract: word, offset, size, signed -> rdata
  - merge: word, offset, size, wdata -> merged word
- The FSM instantiates mau_lane once for each function.

Test Plan:
- Memory preloaded MEM[i]=i. lw 0x14 -> cycle 1 shows mem_re=1, mem_a=5; cycle 2 shows resp_valid=1, rdata=0x00000005, err=0.
- sb 0x21, wdata 0x000000AB -> cycle 1 shows mem_re with mem_a=8; cycle 2 shows mem_we with mem_wd=0x0000AB08; resp at cycle 3. Follow with lb 0x21 signed -> 0xFFFFFFAB, then lbu 0x21 -> 0x000000AB.
- sh 0x12, wdata 0x1234BEEF -> MEM[4]=0xBEEF0004. Then lh 0x12 signed -> 0xFFFFBEEF, and lw 0x10 -> 0xBEEF0004.
- Errors, each with resp at cycle 1, err=1, and no mem_re/mem_we:
  - lh 0x07
  - lw 0x02
  - sw 0x400 (word 256)
  - req_size=3
- req_valid held high with two queued loads 0x00 then 0x04 -> req_ready=0 while busy; second accepted the cycle after its predecessor's resp; responses 0x0, 0x1 in order.
- sb 0x21 with rst pulsed low during RMW_RD -> mem_we never asserted, resp_valid never asserted, outputs 0, req_ready=1 immediately.
